// File: rtl/npu_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : npu_tile_scheduler
//  Purpose  : Command sequencer in front of the tile processor. Accepts one
//             matrix command (op code + tile-grid size), walks every
//             (tile_i, tile_j) pair in row-major order, pulses tp_start for
//             each tile and waits for tp_done. Reports completion, progress
//             and error/abort status to the host.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          : clock, asynchronous active-low reset
//    cmd_valid/ready     : command handshake (op, rows, cols)
//    cmd_op              : 0=MUL 1=ADD 2=SUB 3=CONV 4=DOT
//    cmd_rows/cmd_cols   : tile grid size, legal 1..8
//    abort               : host abort request
//    tp_start            : one-cycle start pulse to the tile processor
//    tp_tile_i/j         : current tile coordinates
//    tp_op_code          : latched op code
//    tp_done             : tile processor done (level or pulse)
//    busy                : command in progress
//    sched_done          : one-cycle pulse at command end
//    err / err_code      : sticky error, 0 none 1 bad cmd 2 timeout 3 abort
//    tiles_done          : tiles completed for the current/last command
// ============================================================================
module npu_tile_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_rows,
    input  logic [3:0] cmd_cols,
    input  logic       abort,
    output logic       tp_start,
    output logic [2:0] tp_tile_i,
    output logic [2:0] tp_tile_j,
    output logic [2:0] tp_op_code,
    input  logic       tp_done,
    output logic       busy,
    output logic       sched_done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [6:0] tiles_done
);

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_err_none    = 2'd0;
    localparam logic [1:0] c_err_bad     = 2'd1;
    localparam logic [1:0] c_err_timeout = 2'd2;
    localparam logic [1:0] c_err_abort   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t           r_state;
    logic [3:0]       r_rows;
    logic [3:0]       r_cols;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_armed;
    logic             r_start;

    logic w_cmd_bad;
    logic w_done_hit;
    logic w_timeout;
    logic w_more_cols;
    logic w_more_rows;

    assign w_cmd_bad   = (cmd_op > 3'd4)
                       || (cmd_rows == 4'd0) || (cmd_rows > 4'd8)
                       || (cmd_cols == 4'd0) || (cmd_cols > 4'd8);
    // A done level carried over from the previous tile only counts once the
    // tile processor has been seen low at least once in this WAIT.
    assign w_done_hit  = r_armed && tp_done;
    assign w_timeout   = (r_wait_cnt == c_timeout_last);
    assign w_more_cols = ({1'b0, tp_tile_j} < (r_cols - 4'd1));
    assign w_more_rows = ({1'b0, tp_tile_i} < (r_rows - 4'd1));

    // The start pulse is registered; an abort sampled in the same ISSUE cycle
    // masks it so the tile processor never sees a start for an aborted tile.
    assign tp_start = r_start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rows     <= 4'd0;
            r_cols     <= 4'd0;
            r_wait_cnt <= '0;
            r_armed    <= 1'b0;
            r_start    <= 1'b0;
            cmd_ready  <= 1'b1;
            tp_tile_i  <= 3'd0;
            tp_tile_j  <= 3'd0;
            tp_op_code <= 3'd0;
            busy       <= 1'b0;
            sched_done <= 1'b0;
            err        <= 1'b0;
            err_code   <= c_err_none;
            tiles_done <= 7'd0;
        end else begin
            r_start    <= 1'b0;
            sched_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        tp_op_code <= cmd_op;
                        r_rows     <= cmd_rows;
                        r_cols     <= cmd_cols;
                        tp_tile_i  <= 3'd0;
                        tp_tile_j  <= 3'd0;
                        tiles_done <= 7'd0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (w_cmd_bad) begin
                            err        <= 1'b1;
                            err_code   <= c_err_bad;
                            sched_done <= 1'b1;
                            r_state    <= S_FINISH;
                        end else begin
                            err        <= 1'b0;
                            err_code   <= c_err_none;
                            r_start    <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_armed    <= 1'b0;
                    if (abort) begin
                        err        <= 1'b1;
                        err_code   <= c_err_abort;
                        sched_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        err        <= 1'b1;
                        err_code   <= c_err_abort;
                        sched_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else if (w_done_hit) begin
                        tiles_done <= tiles_done + 7'd1;
                        r_state    <= S_NEXT;
                    end else if (w_timeout) begin
                        err        <= 1'b1;
                        err_code   <= c_err_timeout;
                        sched_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (!tp_done) begin
                            r_armed <= 1'b1;
                        end
                    end
                end

                S_NEXT: begin
                    if (abort) begin
                        err        <= 1'b1;
                        err_code   <= c_err_abort;
                        sched_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else if (w_more_cols) begin
                        tp_tile_j  <= tp_tile_j + 3'd1;
                        r_start    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else if (w_more_rows) begin
                        tp_tile_j  <= 3'd0;
                        tp_tile_i  <= tp_tile_i + 3'd1;
                        r_start    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        sched_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npu_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_tile_scheduler
//  Purpose  : Scoreboard bench for npu_tile_scheduler. A driver issues
//             commands and pushes the expected tile starts and command end
//             into queues; a monitor pops and compares them as the DUT
//             presents tp_start / sched_done. A responder process plays the
//             tile processor in several done-signalling styles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_npu_tile_scheduler;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_rows;
    logic [3:0] cmd_cols;
    logic       abort;
    logic       tp_start;
    logic [2:0] tp_tile_i;
    logic [2:0] tp_tile_j;
    logic [2:0] tp_op_code;
    logic       tp_done;
    logic       busy;
    logic       sched_done;
    logic       err;
    logic [1:0] err_code;
    logic [6:0] tiles_done;

    npu_tile_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rows   (cmd_rows),
        .cmd_cols   (cmd_cols),
        .abort      (abort),
        .tp_start   (tp_start),
        .tp_tile_i  (tp_tile_i),
        .tp_tile_j  (tp_tile_j),
        .tp_op_code (tp_op_code),
        .tp_done    (tp_done),
        .busy       (busy),
        .sched_done (sched_done),
        .err        (err),
        .err_code   (err_code),
        .tiles_done (tiles_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int j;
        int op;
        int gap;
    } start_t;

    typedef struct {
        int err;
        int code;
        int tiles;
        int gap;
    } end_t;

    start_t sq[$];
    end_t   eq[$];

    int vectors = 0;
    int fails   = 0;

    // responder configuration: 0 pulse after d cycles, 1 never done,
    // 2 level held across next start then low for one cycle,
    // 3 level held forever after the first tile
    int resp_mode = 0;
    int resp_d    = 5;
    int resp_hold = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int mcyc    = 0;
    int last_ev = 0;
    initial begin
        start_t s;
        end_t   e;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst_n) begin
                if (cmd_valid && cmd_ready) last_ev = mcyc;
                if (tp_start) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_start", 1, 0);
                    end else begin
                        s = sq.pop_front();
                        chk("start_tile_i", int'(tp_tile_i), s.i);
                        chk("start_tile_j", int'(tp_tile_j), s.j);
                        chk("start_op", int'(tp_op_code), s.op);
                        chk("start_gap", mcyc - last_ev, s.gap);
                    end
                    last_ev = mcyc;
                end
                if (sched_done) begin
                    if (eq.size() == 0) begin
                        chk("unexpected_sched_done", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        chk("end_err", int'(err), e.err);
                        chk("end_code", int'(err_code), e.code);
                        chk("end_tiles", int'(tiles_done), e.tiles);
                        chk("end_gap", mcyc - last_ev, e.gap);
                        chk("end_starts_left", sq.size(), 0);
                        chk("end_busy", int'(busy), 1);
                    end
                    last_ev = mcyc;
                end
            end
        end
    end

    // ---------------- tile processor responder ----------------
    initial begin
        int since;
        int nst;
        bit started;
        since   = 0;
        nst     = 0;
        started = 0;
        tp_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                started = 0;
                tp_done = 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                started = 0;
                nst     = 0;
                tp_done = 1'b0;
            end else begin
                if (tp_start) begin
                    started = 1;
                    since   = 0;
                    nst++;
                end else if (started) begin
                    since++;
                end
                if (started) begin
                    case (resp_mode)
                        0: tp_done = (since == resp_d);
                        1: tp_done = 1'b0;
                        2: tp_done = (nst == 1) ? (since >= resp_d) : (since != resp_hold + 1);
                        default: tp_done = (nst == 1) ? (since >= resp_d) : 1'b1;
                    endcase
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tp_start", int'(tp_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sched_done", int'(sched_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_tiles_done", int'(tiles_done), 0);
        chk("rst_tile_ij_op", int'({tp_tile_i, tp_tile_j, tp_op_code}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy_after", int'(busy), 0);
    endtask

    // Issue one command; the expected responses come from the tile-grid rules:
    // tiles run row-major, first start one cycle after accept, each following
    // start (or the final sched_done) two cycles after the tile completes.
    task automatic run_cmd(input int op, input int rows, input int cols,
                           input int mode, input int d, input int hold,
                           input int ab_tile, input int ab_w, input int rst_tile);
        bit     bad;
        bit     ended;
        bit     fin;
        int     n;
        int     c_prev;
        int     nst;
        int     cd;
        start_t s;
        end_t   e;

        bad = (op > 4) || (rows < 1) || (rows > 8) || (cols < 1) || (cols > 8);
        resp_mode = (mode == 4) ? 0 : mode;
        resp_d    = d;
        resp_hold = hold;
        e         = '{0, 0, 0, 0};
        if (bad) begin
            e = '{1, 1, 0, 1};
            eq.push_back(e);
        end else begin
            n      = rows * cols;
            c_prev = 0;
            ended  = 0;
            for (int t = 0; t < n && !ended; t++) begin
                s = '{t / cols, t % cols, op, (t == 0) ? 1 : c_prev + 2};
                sq.push_back(s);
                if (t == rst_tile) begin
                    ended = 1;
                end else if (t == ab_tile) begin
                    e = '{1, 3, t, ab_w + 1};
                    eq.push_back(e);
                    ended = 1;
                end else if (mode == 1 || (mode == 3 && t > 0)) begin
                    e = '{1, 2, t, TO + 1};
                    eq.push_back(e);
                    ended = 1;
                end else begin
                    c_prev = (mode == 2 && t > 0) ? hold + 2 : d;
                    if (t == n - 1) begin
                        e = '{0, 0, n, c_prev + 2};
                        eq.push_back(e);
                    end
                end
            end
        end

        // an idle-time abort must be ignored
        @(posedge clk);
        #1;
        abort = $urandom_range(0, 1);
        @(posedge clk);
        #1;
        abort     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_rows  = 4'(rows);
        cmd_cols  = 4'(cols);
        nst = 0;
        cd  = -1;
        fin = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                cmd_valid = 1'b0;
                cmd_op    = 3'($urandom);
                cmd_rows  = 4'($urandom);
                cmd_cols  = 4'($urandom);
            end
            if (abort) abort = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (rst_tile >= 0) begin
                        do_reset();
                        chk("rst_starts_left", sq.size(), 0);
                        chk("rst_ends_left", eq.size(), 0);
                        sq.delete();
                        eq.delete();
                        fin = 1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            if (!fin && tp_start) begin
                if (nst == ab_tile || nst == rst_tile) cd = ab_w;
                nst++;
            end
            if (!fin && sched_done) fin = 1;
        end
        if (!fin) begin
            chk("cmd_completion_budget", 0, 1);
            do_reset();
            sq.delete();
            eq.delete();
        end else if (rst_tile < 0) begin
            @(posedge clk);
            #1;
            chk("post_cmd_ready", int'(cmd_ready), 1);
            chk("post_busy", int'(busy), 0);
            chk("post_sched_done", int'(sched_done), 0);
            chk("post_err_hold", int'(err), e.err);
            chk("post_code_hold", int'(err_code), e.code);
            chk("post_tiles_hold", int'(tiles_done), e.tiles);
            chk("post_queues_empty", sq.size() + eq.size(), 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int op;
        int rows;
        int cols;
        int sel;
        int d;
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rows  = 4'd0;
        cmd_cols  = 4'd0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_cmd_ready", int'(cmd_ready), 1);
        chk("init_busy", int'(busy), 0);
        chk("init_err", int'(err), 0);
        chk("init_tiles", int'(tiles_done), 0);
        rst_n = 1'b1;

        // directed: op, rows, cols, mode, d, hold, ab_tile, ab_w, rst_tile
        run_cmd(0, 2, 3, 0, 5, 0, -1, 0, -1);   // MUL 2x3, done 5 cycles after start
        run_cmd(5, 2, 2, 0, 5, 0, -1, 0, -1);   // bad op
        run_cmd(1, 0, 2, 0, 5, 0, -1, 0, -1);   // bad rows
        run_cmd(2, 2, 9, 0, 5, 0, -1, 0, -1);   // bad cols
        run_cmd(3, 2, 2, 1, 5, 0, -1, 0, -1);   // timeout on first tile
        run_cmd(4, 2, 2, 2, 3, 2, -1, 0, -1);   // done level held across starts
        run_cmd(0, 2, 2, 3, 3, 0, -1, 0, -1);   // done never drops -> timeout
        run_cmd(0, 2, 2, 4, 5, 0,  2, 2, -1);   // abort in WAIT of 3rd tile
        run_cmd(0, 2, 3, 0, 5, 0, -1, 2,  1);   // reset mid-WAIT
        run_cmd(1, 1, 1, 0, 3, 0, -1, 0, -1);   // ADD 1x1 after reset
        run_cmd(4, 8, 8, 0, 2, 0, -1, 0, -1);   // largest grid

        for (int k = 0; k < 25; k++) begin
            op   = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            rows = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15))
                                               : $urandom_range(1, 4);
            cols = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15))
                                               : $urandom_range(1, 8);
            d    = $urandom_range(2, 6);
            n    = rows * cols;
            if (n < 1) n = 1;
            sel  = $urandom_range(0, 9);
            if (sel <= 5)      run_cmd(op, rows, cols, 0, d, 0, -1, 0, -1);
            else if (sel == 6) run_cmd(op, rows, cols, 1, d, 0, -1, 0, -1);
            else if (sel == 7) run_cmd(op, rows, cols, 2, d, $urandom_range(0, 4), -1, 0, -1);
            else if (sel == 8) run_cmd(op, rows, cols, 3, d, 0, -1, 0, -1);
            else               run_cmd(op, rows, cols, 4, d, 0, $urandom_range(0, n - 1),
                                       $urandom_range(1, d - 1), -1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
